// File: rtl/spi_byte_rx_pkg.sv
// Shared types and constants for the SPI mode-0 byte receiver.
package spi_rx_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } spi_state_e;

   localparam logic SPI_IDLE_SS   = 1'b1;
   localparam logic SPI_IDLE_SCLK = 1'b0;

   function automatic int bit_cnt_width(input int data_w);
      return (data_w > 1) ? $clog2(data_w) : 1;
   endfunction

endpackage

// File: rtl/spi_byte_rx_if.sv
// SPI pin bundle: the master drives ss/sclk/mosi, the slave drives miso.
interface spi_byte_rx_if;

   logic ss;
   logic sclk;
   logic mosi;
   logic miso;

   modport master (output ss, output sclk, output mosi, input miso);
   modport slave  (input ss, input sclk, input mosi, output miso);

endinterface

// File: rtl/spi_byte_rx_sync_edge.sv
// Multi-stage pin synchronizer with rise/fall detection against the previous synced value.
module spi_sync_edge
   import spi_rx_pkg::*;
#(
   parameter int   SYNC_STAGES = 2,
   parameter logic IDLE_VAL    = SPI_IDLE_SCLK
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic dout,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   prev_q, prev_d;

   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], din};
      prev_d = sync_q[SYNC_STAGES-1];
   end

   // Preset to the pin's idle level so reset never manufactures an edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= {SYNC_STAGES{IDLE_VAL}};
         prev_q <= IDLE_VAL;
      end else begin
         sync_q <= sync_d;
         prev_q <= prev_d;
      end
   end

   assign dout = sync_q[SYNC_STAGES-1];
   assign rise = dout & ~prev_q;
   assign fall = ~dout & prev_q;

endmodule

// File: rtl/spi_byte_rx.sv
// SPI mode-0 slave byte receiver, MSB first, oversampled in the clk domain.
// Define SPI_RX_ECHO_EN to echo the previously received byte on miso.
module spi_byte_rx
   import spi_rx_pkg::*;
#(
   parameter int DATA_W      = 8,
   parameter int SYNC_STAGES = 2,
   parameter int CNT_W       = 8
) (
   input  logic              clk,
   input  logic              rst,
   spi_byte_rx_if.slave      spi,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_valid,
   output logic              frame_active,
   output logic [CNT_W-1:0]  byte_cnt
);

   localparam int              BIT_W    = bit_cnt_width(DATA_W);
   localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

   logic ss_s, ss_rise, ss_fall;
   logic sclk_s, sclk_rise, sclk_fall;
   logic mosi_s;
   logic unused_sclk;

   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .IDLE_VAL(SPI_IDLE_SS)) u_ss_sync (
      .clk(clk), .rst(rst), .din(spi.ss), .dout(ss_s), .rise(ss_rise), .fall(ss_fall)
   );

   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .IDLE_VAL(SPI_IDLE_SCLK)) u_sclk_sync (
      .clk(clk), .rst(rst), .din(spi.sclk), .dout(sclk_s), .rise(sclk_rise), .fall(sclk_fall)
   );

   logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
   logic [SYNC_STAGES-1:0] settle_q, settle_d;
   logic                   armed_q, armed_d;
   logic                   settled;

   // A frame may only start once ss has been seen high with the synchronizer refilled
   // from the real pin, so a reset in mid-frame waits for ss to deassert first.
   always_comb begin
      mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi.mosi};
      settle_d    = {settle_q[SYNC_STAGES-2:0], 1'b1};
      armed_d     = armed_q | (settled & ss_s);
   end

   assign mosi_s  = mosi_sync_q[SYNC_STAGES-1];
   assign settled = settle_q[SYNC_STAGES-1];

   spi_state_e state_q, state_d;
   logic       frame_start, shift_en, byte_done;

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (armed_q && ss_fall) state_d = SHIFT;
         SHIFT:   if (ss_rise)            state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      frame_active = (state_q == SHIFT);
      frame_start  = (state_q == IDLE) && (state_d == SHIFT);
      shift_en     = frame_active && sclk_rise;
      byte_done    = shift_en && (bit_cnt_q == LAST_BIT);
   end

   logic [DATA_W-1:0] shreg_q, shreg_d, shifted;
   logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
   logic [DATA_W-1:0] rx_data_q, rx_data_d;
   logic              rx_valid_q, rx_valid_d;
   logic [CNT_W-1:0]  byte_cnt_q, byte_cnt_d;

   assign shifted = {shreg_q[DATA_W-2:0], mosi_s};

   always_comb begin
      shreg_d    = shreg_q;
      bit_cnt_d  = bit_cnt_q;
      rx_data_d  = rx_data_q;
      byte_cnt_d = byte_cnt_q;
      rx_valid_d = byte_done;
      if (!frame_active) begin
         shreg_d   = '0;
         bit_cnt_d = '0;
         if (frame_start) byte_cnt_d = '0;
      end else if (shift_en) begin
         shreg_d = shifted;
         if (byte_done) begin
            bit_cnt_d  = '0;
            rx_data_d  = shifted;
            byte_cnt_d = byte_cnt_q + CNT_W'(1);
         end else begin
            bit_cnt_d  = bit_cnt_q + BIT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mosi_sync_q <= '0;
         settle_q    <= '0;
         armed_q     <= 1'b0;
         shreg_q     <= '0;
         bit_cnt_q   <= '0;
         rx_data_q   <= '0;
         rx_valid_q  <= 1'b0;
         byte_cnt_q  <= '0;
      end else begin
         mosi_sync_q <= mosi_sync_d;
         settle_q    <= settle_d;
         armed_q     <= armed_d;
         shreg_q     <= shreg_d;
         bit_cnt_q   <= bit_cnt_d;
         rx_data_q   <= rx_data_d;
         rx_valid_q  <= rx_valid_d;
         byte_cnt_q  <= byte_cnt_d;
      end
   end

   assign rx_data  = rx_data_q;
   assign rx_valid = rx_valid_q;
   assign byte_cnt = byte_cnt_q;

`ifdef SPI_RX_ECHO_EN
   logic [DATA_W-1:0] tx_q, tx_d;

   // The fall right after a completed byte keeps the freshly loaded MSB on the pin.
   always_comb begin
      tx_d = tx_q;
      if (frame_start)
         tx_d = rx_data_q;
      else if (byte_done)
         tx_d = shifted;
      else if (frame_active && sclk_fall && (bit_cnt_q != '0))
         tx_d = {tx_q[DATA_W-2:0], 1'b0};
   end

   always_ff @(posedge clk) begin
      if (rst) tx_q <= '0;
      else     tx_q <= tx_d;
   end

   assign spi.miso    = frame_active & tx_q[DATA_W-1];
   assign unused_sclk = sclk_s;
`else
   assign spi.miso    = 1'b0;
   assign unused_sclk = ^{sclk_s, sclk_fall};
`endif

endmodule

// File: tb/tb_spi_byte_rx.sv
// Self-checking bench for spi_byte_rx: vector table plus hand-written frame corner cases.
module tb_spi_byte_rx;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       frame_active;
   logic [7:0] byte_cnt;

   spi_byte_rx_if spi_bus ();

   spi_byte_rx #(.DATA_W(8), .SYNC_STAGES(2), .CNT_W(8)) dut (
      .clk(clk),
      .rst(rst),
      .spi(spi_bus),
      .rx_data(rx_data),
      .rx_valid(rx_valid),
      .frame_active(frame_active),
      .byte_cnt(byte_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] data;
      logic [7:0] cnt;
   } exp_t;

   typedef struct {
      logic [7:0] byte_val;
      bit         start_frame;
      bit         end_frame;
      logic [7:0] exp_cnt;
   } vec_t;

   exp_t       sb[$];
   exp_t       mon_e;
   int         errors = 0;
   int         checks = 0;
   int         pulses = 0;
   int         hp = 6;
   logic [7:0] last_byte = 8'h00;
   logic [7:0] mw;
   vec_t       vecs[5];
   vec_t       v;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Every rx_valid pulse consumes one expected byte from the scoreboard
   always @(negedge clk) begin
      if (rx_valid) begin
         pulses++;
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_rx_valid: got data 0x%0h, expected no pulse", rx_data);
         end else begin
            mon_e = sb.pop_front();
            checkOutput("sb_rx_data", 32'(rx_data), 32'(mon_e.data));
            checkOutput("sb_byte_cnt", 32'(byte_cnt), 32'(mon_e.cnt));
         end
      end
   end

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation still running, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic logic [7:0] exp_echo();
`ifdef SPI_RX_ECHO_EN
      return last_byte;
`else
      return 8'h00;
`endif
   endfunction

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic start_frame();
      spi_bus.ss = 1'b0;
      wait_clk(2 * hp);
   endtask

   task automatic end_frame();
      wait_clk(hp);
      spi_bus.ss = 1'b1;
      wait_clk(2 * hp);
   endtask

   // Drive nbits MSB first, sampling miso just before each rising sclk edge
   task automatic send_bits(input logic [7:0] b, input int nbits, output logic [7:0] miso_word);
      miso_word = 8'h00;
      for (int i = 0; i < nbits; i++) begin
         spi_bus.mosi = b[7 - i];
         wait_clk(hp);
         miso_word = {miso_word[6:0], spi_bus.miso};
         spi_bus.sclk = 1'b1;
         wait_clk(hp);
         spi_bus.sclk = 1'b0;
      end
   endtask

   // One full byte: expectation pushed before driving, then echo and outputs compared
   task automatic applyStimulus(input vec_t sv);
      logic [7:0] echo_word;
      if (sv.start_frame) begin
         start_frame();
         checkOutput("byte_cnt_frame_clear", 32'(byte_cnt), 0);
      end
      sb.push_back('{data: sv.byte_val, cnt: sv.exp_cnt});
      send_bits(sv.byte_val, 8, echo_word);
      checkOutput("miso_echo", 32'(echo_word), 32'(exp_echo()));
      last_byte = sv.byte_val;
      checkOutput("rx_data", 32'(rx_data), 32'(sv.byte_val));
      checkOutput("byte_cnt", 32'(byte_cnt), 32'(sv.exp_cnt));
      if (sv.end_frame) end_frame();
   endtask

   initial begin
      vecs[0] = '{byte_val: 8'h3C, start_frame: 1'b1, end_frame: 1'b0, exp_cnt: 8'd1};
      vecs[1] = '{byte_val: 8'hFF, start_frame: 1'b0, end_frame: 1'b1, exp_cnt: 8'd2};
      vecs[2] = '{byte_val: 8'h12, start_frame: 1'b1, end_frame: 1'b0, exp_cnt: 8'd1};
      vecs[3] = '{byte_val: 8'h34, start_frame: 1'b0, end_frame: 1'b1, exp_cnt: 8'd2};
      vecs[4] = '{byte_val: 8'hC3, start_frame: 1'b1, end_frame: 1'b1, exp_cnt: 8'd1};

      spi_bus.ss   = 1'b1;
      spi_bus.sclk = 1'b0;
      spi_bus.mosi = 1'b0;
      rst          = 1'b1;
      wait_clk(3);
      checkOutput("reset_miso", 32'(spi_bus.miso), 0);
      checkOutput("reset_rx_data", 32'(rx_data), 0);
      checkOutput("reset_rx_valid", 32'(rx_valid), 0);
      checkOutput("reset_frame_active", 32'(frame_active), 0);
      checkOutput("reset_byte_cnt", 32'(byte_cnt), 0);
      rst = 1'b0;
      wait_clk(4);

      $display("[TB] single byte 0xA5, sclk half-period 4");
      hp = 4;
      v = '{byte_val: 8'hA5, start_frame: 1'b1, end_frame: 1'b0, exp_cnt: 8'd1};
      applyStimulus(v);
      checkOutput("frame_active_in_frame", 32'(frame_active), 1);
      end_frame();
      checkOutput("frame_active_after_ss", 32'(frame_active), 0);
      checkOutput("pulses_single", 32'(pulses), 1);

      $display("[TB] vector table");
      hp = 6;
      for (int i = 0; i < 5; i++) applyStimulus(vecs[i]);
      checkOutput("pulses_table", 32'(pulses), 6);

      $display("[TB] abort after 5 bits");
      start_frame();
      send_bits(8'h96, 5, mw);
      end_frame();
      checkOutput("abort_pulses", 32'(pulses), 6);
      checkOutput("abort_rx_data_hold", 32'(rx_data), 'hC3);
      checkOutput("abort_byte_cnt_hold", 32'(byte_cnt), 0);
      checkOutput("abort_frame_active", 32'(frame_active), 0);
      v = '{byte_val: 8'h81, start_frame: 1'b1, end_frame: 1'b1, exp_cnt: 8'd1};
      applyStimulus(v);

      $display("[TB] reset in mid-frame");
      start_frame();
      send_bits(8'hE7, 3, mw);
      rst = 1'b1;
      wait_clk(1);
      rst = 1'b0;
      send_bits(8'hFF, 8, mw);
      checkOutput("rst_mid_pulses", 32'(pulses), 7);
      checkOutput("rst_mid_rx_data", 32'(rx_data), 0);
      checkOutput("rst_mid_byte_cnt", 32'(byte_cnt), 0);
      checkOutput("rst_mid_frame_active", 32'(frame_active), 0);
      checkOutput("rst_mid_miso", 32'(spi_bus.miso), 0);
      last_byte = 8'h00;
      end_frame();
      v = '{byte_val: 8'h5A, start_frame: 1'b1, end_frame: 1'b1, exp_cnt: 8'd1};
      applyStimulus(v);

      $display("[TB] 257 bytes in one frame");
      hp = 4;
      for (int i = 0; i < 257; i++) begin
         v.byte_val    = 8'(i) ^ 8'h5C;
         v.start_frame = (i == 0);
         v.end_frame   = (i == 256);
         v.exp_cnt     = 8'(i + 1);
         applyStimulus(v);
         if (i == 255) checkOutput("byte_cnt_after_256", 32'(byte_cnt), 0);
      end
      checkOutput("byte_cnt_after_257", 32'(byte_cnt), 1);

      checkOutput("scoreboard_empty", 32'(sb.size()), 0);
      checkOutput("pulses_total", 32'(pulses), 265);
      $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
